// File: rtl/instr_wb_pipelined_slave.sv
// Instrumented Wishbone B4 pipelined slave: queues up to DEPTH requests, answers in order
// after a minimum latency, with error injection, response hold-off and request sniffing.
module instr_wb_pipelined_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [ADDR_WIDTH-1:0]       wb_adr_i,
    input  logic [DATA_WIDTH-1:0]       wb_dat_i,
    output logic [DATA_WIDTH-1:0]       wb_dat_o,
    input  logic                        wb_we_i,
    input  logic [DATA_WIDTH/8-1:0]     wb_sel_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_cyc_i,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic                        wb_stall_o,
    input  logic                        stall_request_i,
    input  logic                        response_hold_i,
    input  logic                        error_request_i,
    input  logic [DATA_WIDTH-1:0]       injected_data_i,
    output logic [ADDR_WIDTH-1:0]       sniffed_adr_o,
    output logic [DATA_WIDTH-1:0]       sniffed_dat_o,
    output logic [DATA_WIDTH/8-1:0]     sniffed_sel_o,
    output logic                        sniffed_we_o,
    output logic                        sniffed_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]  outstanding_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGE_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [AGE_W-1:0] AGE_READY = AGE_W'(LATENCY - 1);

    // Age saturates at AGE_READY, so it never needs more bits than LATENCY-1.
    typedef struct packed {
        logic             we;
        logic             err;
        logic [AGE_W-1:0] age;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    entry_t           head;
    logic             accept;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Full is judged on the registered count only; a same-edge pop is not credited.
    assign wb_stall_o = rst_i | stall_request_i | (count_q == CNT_FULL);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign head       = fifo_q[rd_ptr_q];
    assign pop        = (count_q != '0) & (head.age >= AGE_READY) & wb_cyc_i & ~response_hold_i;

    assign outstanding_o = count_q;

    // NOTE: queue storage has no reset; count_q alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (wr_ptr_q == PTR_W'(i))) begin
                fifo_q[i] <= '{we: wb_we_i, err: error_request_i, age: '0};
            end else if (fifo_q[i].age != AGE_READY) begin
                fifo_q[i].age <= fifo_q[i].age + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!wb_cyc_i) begin
            // Aborted cycle: every queued request is dropped silently.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)    rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= pop & ~head.err;
            wb_err_o <= pop & head.err;
            wb_dat_o <= (pop && !head.err && !head.we) ? injected_data_i : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sniffed_adr_o   <= '0;
            sniffed_dat_o   <= '0;
            sniffed_sel_o   <= '0;
            sniffed_we_o    <= 1'b0;
            sniffed_valid_o <= 1'b0;
        end else begin
            sniffed_valid_o <= accept;
            if (accept) begin
                sniffed_adr_o <= wb_adr_i;
                sniffed_dat_o <= wb_dat_i;
                sniffed_sel_o <= wb_sel_i;
                sniffed_we_o  <= wb_we_i;
            end
        end
    end

endmodule

// File: tb/tb_instr_wb_pipelined_slave.sv
// Randomised scoreboard bench for instr_wb_pipelined_slave: a timestamp-based request queue
// predicts responses and sniff/outstanding values; a negedge monitor compares them.
module tb_instr_wb_pipelined_slave;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          we;
    logic [SW-1:0] sel;
    logic          stb;
    logic          cyc;
    logic          ack;
    logic          err;
    logic          stall;
    logic          sreq;
    logic          hold;
    logic          ereq;
    logic [DW-1:0] inj;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [SW-1:0] s_sel;
    logic          s_we;
    logic          s_valid;
    logic [CW-1:0] outstanding;

    always #5 clk = ~clk;

    instr_wb_pipelined_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_we_i(we),
        .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack), .wb_err_o(err), .wb_stall_o(stall),
        .stall_request_i(sreq), .response_hold_i(hold), .error_request_i(ereq),
        .injected_data_i(inj),
        .sniffed_adr_o(s_adr), .sniffed_dat_o(s_dat), .sniffed_sel_o(s_sel),
        .sniffed_we_o(s_we), .sniffed_valid_o(s_valid), .outstanding_o(outstanding)
    );

    typedef struct {
        logic          we;
        logic          err;
        int            acc;
    } req_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] dat;
        int            at;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    int    edge_cnt = 0;
    bit    started  = 0;
    int    errors   = 0;
    int    checks   = 0;

    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic          e_we;
    logic          e_sv;
    int            e_out;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, got, exp);
        end
    endtask

    // Reference model: a request accepted at edge a may answer at edge e once e-a >= LAT,
    // only from the head, only while cyc is high and hold is low.
    always @(posedge clk) begin : model
        req_t  r;
        resp_t p;
        bit    full;
        edge_cnt++;
        started = 1;
        if (rst) begin
            req_q.delete();
            e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_sv = 1'b0;
        end else begin
            full = (req_q.size() == DEPTH);
            if (req_q.size() > 0 && cyc && !hold && (edge_cnt - req_q[0].acc) >= LAT) begin
                r     = req_q.pop_front();
                p.err = r.err;
                p.dat = (!r.we && !r.err) ? inj : '0;
                p.at  = edge_cnt;
                resp_q.push_back(p);
            end
            if (!cyc) req_q.delete();
            if (cyc && stb && !sreq && !full) begin
                r.we  = we;
                r.err = ereq;
                r.acc = edge_cnt;
                req_q.push_back(r);
                e_adr = adr; e_dat = dat_w; e_sel = sel; e_we = we;
                e_sv  = 1'b1;
            end else begin
                e_sv = 1'b0;
            end
        end
        e_out = req_q.size();
    end

    always @(negedge clk) begin : monitor
        resp_t p;
        if (started) begin
            check("ack_err_together", {ack, err}, (ack && err) ? 2'b01 : {ack, err});
            if (ack || err) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp at edge %0d: ack=%b err=%b, expected no response",
                             edge_cnt, ack, err);
                end else begin
                    p = resp_q.pop_front();
                    check("resp_is_err", err, p.err);
                    check("resp_dat", dat_r, p.dat);
                    check("resp_edge", edge_cnt, p.at);
                end
            end else begin
                check("idle_dat", dat_r, '0);
                if (resp_q.size() > 0 && resp_q[0].at <= edge_cnt) begin
                    p = resp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_resp at edge %0d: no ack/err, expected %s due at edge %0d",
                             edge_cnt, p.err ? "err" : "ack", p.at);
                end
            end
            check("outstanding", outstanding, e_out);
            check("sniff_valid", s_valid, e_sv);
            check("sniff_adr", s_adr, e_adr);
            check("sniff_dat", s_dat, e_dat);
            check("sniff_sel", s_sel, e_sel);
            check("sniff_we", s_we, e_we);
            check("stall", stall, rst || sreq || (req_q.size() == DEPTH));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // pct_* are percentages of cycles in which the signal is asserted.
    task automatic random_cycles(input int n, input int pct_stb, input int pct_sreq,
                                 input int pct_hold, input int pct_err,
                                 input int pct_drop, input int pct_rst);
        for (int i = 0; i < n; i++) begin
            rst   = ($urandom_range(99) < pct_rst);
            cyc   = ($urandom_range(99) >= pct_drop);
            stb   = ($urandom_range(99) < pct_stb);
            sreq  = ($urandom_range(99) < pct_sreq);
            hold  = ($urandom_range(99) < pct_hold);
            ereq  = ($urandom_range(99) < pct_err);
            we    = $urandom_range(1);
            adr   = AW'($urandom);
            dat_w = $urandom;
            sel   = SW'($urandom);
            inj   = $urandom;
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sreq = 1'b0; hold = 1'b0;
        ereq = 1'b0; adr = '0; dat_w = '0; sel = '0; inj = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single read with known data, then let it drain.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0100; sel = 4'hF; inj = 32'hDEAD_BEEF;
        next_cycle();
        stb = 1'b0;
        repeat (LAT + 3) next_cycle();

        // Back-to-back writes: the queue fills and stalls, then drains in order.
        stb = 1'b1; we = 1'b1;
        for (int i = 0; i < 12; i++) begin
            adr = AW'(16'h0200 + i); dat_w = $urandom;
            next_cycle();
        end
        stb = 1'b0;
        repeat (LAT + 6) next_cycle();

        // Reads with error injection on the middle one, then a held head.
        stb = 1'b1; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ereq = (i == 1); inj = $urandom;
            next_cycle();
        end
        stb = 1'b0; ereq = 1'b0; hold = 1'b1;
        repeat (LAT + 3) next_cycle();
        hold = 1'b0;
        repeat (LAT + 3) next_cycle();

        random_cycles(800, 70, 10, 15, 20, 0, 0);
        random_cycles(800, 80, 5, 30, 15, 3, 1);
        random_cycles(400, 90, 0, 50, 10, 0, 0);

        // Abort with requests pending, then reset with requests pending.
        rst = 1'b0; cyc = 1'b1; sreq = 1'b0; hold = 1'b1; stb = 1'b1; ereq = 1'b0;
        repeat (3) next_cycle();
        stb = 1'b0; cyc = 1'b0;
        next_cycle();
        cyc = 1'b1; stb = 1'b1;
        repeat (3) next_cycle();
        stb = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0; hold = 1'b0;

        random_cycles(300, 60, 10, 10, 20, 2, 0);
        stb = 1'b0; cyc = 1'b1; hold = 1'b0; sreq = 1'b0; rst = 1'b0;
        repeat (DEPTH * LAT + 10) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
